x4_spi_slave: RTL and testbench
===============================

# x4_spi_slave

Oversampled SPI mode-0 slave that answers the same two-byte command/data protocol our SPI master drives toward the X4 radar. It exposes a 128 x 8 register file on that protocol and serves as the responder side for on-board loopback of the second radar channel and as the bus-functional target in block-level benches. It also gives the FPGA fabric a host port into the same register file and a strobe for every SPI write.

## Interface
- CHIP_ID, 8'h24, read-only value returned at address 0x00
- SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/mosi (≥2)
- clk  in  1  system clock, rising edge; spi_sclk must be ≤ clk/8
- rst  in  1  reset, synchronous, active-high
- spi_sclk  in  1  SPI clock from master, idle low
- spi_cs_n  in  1  chip select, active low
- spi_mosi  in  1  master-out data, MSB first
- spi_miso  out  1  slave-out data
- spi_miso_oe  out  1  MISO drive enable (high only while cs_n low)
- wr_strobe  out  1  one-cycle pulse per completed SPI write
- wr_addr  out  7  address of that write
- wr_data  out  8  data of that write
- frame_err  out  1  one-cycle pulse: cs_n rose with bit count ≠ 0
- busy  out  1  high while a transaction is active
- host_we  in  1  host write enable
- host_addr  in  7  host address
- host_wdata  in  8  host write data
- host_rdata  out  8  registered read data for host_addr, 1-cycle latency

## Operation
- Frame: cs_n falls; byte 0 = {rw, addr[6:0]}, rw=1 read, rw=0 write; subsequent bytes = data. cs_n rises ends frame.
- Burst: after every data byte addr increments, 0x7F wraps to 0x00; direction fixed for whole frame.
- States: IDLE → CMD on synchronized cs_n fall; CMD → DATA after 8th sclk rise; DATA stays DATA per byte; any cs_n rise → IDLE.
- Sampling: MOSI captured on detected sclk rise into 8-bit shift reg; 3-bit bit counter.
- Write: on 8th data-bit rise, reg[addr] <= byte; wr_strobe/wr_addr/wr_data valid same cycle. Address 0x00 writes discarded, no strobe.
- Read: at the sclk fall after a byte boundary in a read frame, load tx shift reg with reg[addr] (0x00 → CHIP_ID) and drive bit 7; next 7 falls shift out bits 6..0. Addr increments at byte completion before next load.
- Write-frame MISO: 0.
- Host port: host_we writes reg[host_addr] (0x00 ignored). Same-cycle SPI write and host write to same address: SPI wins.
- frame_err: cs_n rise while bit counter ≠ 0; partial byte discarded, no write.
- Reset: all regs 0x00; state IDLE; cs_n synchronizer stages reset to 0 so a cs_n already low at reset release yields no fall edge; that frame is ignored until cs_n rises and falls again.
- Reset values: spi_miso 0, spi_miso_oe 0, wr_strobe 0, wr_addr 0, wr_data 0, frame_err 0, busy 0, host_rdata 0.

## Timing
- Edge detect latency: pin edge to internal event = SYNC_STAGES + 1 clk.
- wr_strobe asserts SYNC_STAGES+1 clk after 8th data-bit rising sclk.
- MISO updates SYNC_STAGES+1 clk after falling sclk; sclk ≤ clk/8 guarantees settle ≥ 1 clk before master's next rise.
- spi_miso_oe follows synchronized cs_n (same latency); busy = state ≠ IDLE.
- host_rdata: value of reg[host_addr] sampled at edge N, valid after edge N; reflects a write committed that same edge only on the next cycle.

## Structure
- Shared package: RW bit position, ADDR_W=7, DATA_W=8, state enum {IDLE, CMD, DATA}, ID address constant 0x00.
- Sub-module: spi_edge_sync (SYNC_STAGES flop chain + rise/fall pulse), instantiated for sclk and cs_n; mosi uses plain chain.
- Register file: flop array, single SPI port + single host port.

## Test plan
- Reset, then SPI read 0x00 → MISO byte 0x24, no wr_strobe.
- Write frame {0x05, 0xA5} → one wr_strobe, wr_addr=0x05, wr_data=0xA5; following read of 0x05 returns 0xA5.
- Burst write starting 0x7E, data 0x11,0x22,0x33 → strobes at 0x7E,0x7F,0x00(discarded, no strobe); reads of 0x7E/0x7F give 0x11/0x22, 0x00 still 0x24.
- cs_n rises after 5 data bits of write to 0x10 → frame_err pulse, reg[0x10] unchanged, next frame decodes normally.
- Host writes 0x3C to 0x20 in same cycle SPI write 0x20=0x99 commits → reg[0x20]=0x99; host_rdata next cycle 0x99.
- Assert rst mid-read with cs_n held low, release → no MISO drive, busy 0, until cs_n toggles; next read of 0x05 returns 0x00.

Source files
------------

// File: rtl/x4_spi_slave_pkg.sv
// Shared constants and types for the X4 SPI register-file slave.
package x4_spi_slave_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;
  localparam int NREG   = 1 << ADDR_W;
  localparam int RW_BIT = 7;
  localparam logic [ADDR_W-1:0] ID_ADDR = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_e;

  // Burst address step; wraps 0x7F -> 0x00 by width.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/x4_spi_slave_if.sv
// SPI pin bundle between the master (or bench) and the register-file slave.
interface x4_spi_slave_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (output spi_sclk, spi_cs_n, spi_mosi, input spi_miso, spi_miso_oe);
  modport slave  (input spi_sclk, spi_cs_n, spi_mosi, output spi_miso, spi_miso_oe);
endinterface

// File: rtl/x4_spi_slave_edge_sync.sv
// Synchronizer chain for an asynchronous pin with rise/fall pulses one flop past the chain.
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Stages reset to 0, so a pin already low at reset release produces no fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~last_q;
  assign fall = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/x4_spi_slave.sv
// Oversampled SPI mode-0 slave exposing a 128x8 register file, plus a host port and write strobe.
module x4_spi_slave
  import x4_spi_slave_pkg::*;
#(
  parameter logic [DATA_W-1:0] CHIP_ID     = 8'h24,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  x4_spi_slave_if.slave     spi,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic              busy,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(spi.spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(rst), .din(spi.spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  // MOSI shares the sclk chain depth so the sampled bit lines up with the rise pulse.
  always_ff @(posedge clk) begin
    if (rst) mosi_q <= '0;
    else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi.spi_mosi};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  state_e              state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [DATA_W-2:0]   shift_q;
  logic [DATA_W-1:0]   tx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q, load_q;
  logic                miso_q, oe_q, wr_strobe_q, frame_err_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q, host_rdata_q;
  logic [DATA_W-1:0]   regs_q [NREG];

  logic                byte_done_d, spi_we_d, host_wr_d;
  logic [DATA_W-1:0]   rx_byte_d, rd_byte_d;

  always_comb begin
    rx_byte_d   = {shift_q, mosi_s};
    byte_done_d = sclk_rise && !cs_rise && (state_q != IDLE) && (bit_cnt_q == 3'd7);
    spi_we_d    = byte_done_d && (state_q == DATA) && !rw_q && (addr_q != ID_ADDR);
    host_wr_d   = host_we && (host_addr != ID_ADDR);
    rd_byte_d   = (addr_q == ID_ADDR) ? CHIP_ID : regs_q[addr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      load_q      <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_strobe_q <= spi_we_d;
      frame_err_q <= 1'b0;
      if (spi_we_d) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte_d;
      end
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= CMD;
            oe_q      <= 1'b1;
            bit_cnt_q <= '0;
            load_q    <= 1'b0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
          end
        end
        default: begin
          if (cs_rise) begin
            state_q     <= IDLE;
            oe_q        <= 1'b0;
            miso_q      <= 1'b0;
            load_q      <= 1'b0;
            frame_err_q <= (bit_cnt_q != '0);
            bit_cnt_q   <= '0;
          end else begin
            if (sclk_rise) begin
              shift_q   <= rx_byte_d[DATA_W-2:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (byte_done_d) begin
                if (state_q == CMD) begin
                  state_q <= DATA;
                  rw_q    <= rx_byte_d[RW_BIT];
                  addr_q  <= rx_byte_d[ADDR_W-1:0];
                  load_q  <= rx_byte_d[RW_BIT];
                end else begin
                  addr_q  <= next_addr(addr_q);
                  load_q  <= rw_q;
                end
              end
            end
            // First fall after a read byte boundary loads the next register; later falls shift.
            if (sclk_fall) begin
              if (load_q) begin
                miso_q <= rd_byte_d[DATA_W-1];
                tx_q   <= {rd_byte_d[DATA_W-2:0], 1'b0};
                load_q <= 1'b0;
              end else begin
                miso_q <= tx_q[DATA_W-1];
                tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
      endcase
    end
  end

  // One flop per entry; the SPI port takes priority over the host on a same-address collision.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst)                                      regs_q[gi] <= '0;
        else if (spi_we_d && addr_q == ADDR_W'(gi))   regs_q[gi] <= rx_byte_d;
        else if (host_wr_d && host_addr == ADDR_W'(gi)) regs_q[gi] <= host_wdata;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) host_rdata_q <= '0;
    else     host_rdata_q <= (host_addr == ID_ADDR) ? CHIP_ID : regs_q[host_addr];
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;
  assign wr_strobe       = wr_strobe_q;
  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;
  assign frame_err       = frame_err_q;
  assign busy            = (state_q != IDLE);
  assign host_rdata      = host_rdata_q;

endmodule

// File: tb/tb_x4_spi_slave.sv
// Directed plus randomized bench for x4_spi_slave against a flat register-array model.
module tb_x4_spi_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  x4_spi_slave_if spi();

  logic       wr_strobe, frame_err, busy, host_we;
  logic [6:0] wr_addr, host_addr;
  logic [7:0] wr_data, host_wdata, host_rdata;

  x4_spi_slave #(.CHIP_ID(8'h24), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi(spi),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          fe_cnt   = 0;
  logic [7:0]  tx_buf [16];
  logic [7:0]  rx_buf [16];
  logic [7:0]  model  [128];
  logic [14:0] obs_q [$];
  logic [14:0] exp_q [$];
  logic        strobe_at_commit;
  logic [7:0]  rdata_after;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_strobe) obs_q.push_back({wr_addr, wr_data});
      if (frame_err) fe_cnt++;
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [6:0] a);
    return (a == 7'h00) ? 8'h24 : model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
  endtask

  // Mode-0 master: sclk period is 10 clk, MISO sampled just before each rise.
  task automatic spi_xfer(input int nbits, input int cbit);
    spi.spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    check("oe_in_frame", spi.spi_miso_oe, 1);
    check("busy_in_frame", busy, 1);
    for (int i = 0; i < nbits; i++) begin
      spi.spi_mosi = tx_buf[i/8][7 - i%8];
      repeat (5) @(negedge clk);
      rx_buf[i/8][7 - i%8] = spi.spi_miso;
      spi.spi_sclk = 1'b1;
      if (i == cbit) begin
        repeat (2) @(negedge clk);
        host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
        strobe_at_commit = wr_strobe;
        @(negedge clk);
        rdata_after = host_rdata;
        @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      spi.spi_sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    spi.spi_cs_n = 1'b1;
    spi.spi_mosi = 1'b0;
    repeat (8) @(negedge clk);
    check("oe_after_frame", spi.spi_miso_oe, 0);
    check("busy_after_frame", busy, 0);
  endtask

  task automatic spi_write(input logic [6:0] a, input int n, input int cbit);
    logic [6:0] ak;
    tx_buf[0] = {1'b0, a};
    exp_q = {};
    obs_q = {};
    for (int k = 0; k < n; k++) begin
      ak = a + 7'(k);
      if (ak != 7'h00) begin
        model[ak] = tx_buf[k+1];
        exp_q.push_back({ak, tx_buf[k+1]});
      end
    end
    spi_xfer(8 * (n + 1), cbit);
    check("wr_strobe_count", obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      check("wr_strobe_entry", obs_q[k], exp_q[k]);
    $display("spi write addr=%02h len=%0d strobes=%0d", a, n, obs_q.size());
  endtask

  task automatic spi_read(input logic [6:0] a, input int n);
    logic [6:0] ak;
    tx_buf[0] = {1'b1, a};
    for (int k = 0; k < n; k++) tx_buf[k+1] = 8'($urandom);
    obs_q = {};
    spi_xfer(8 * (n + 1), -1);
    for (int k = 0; k < n; k++) begin
      ak = a + 7'(k);
      check("rd_byte", rx_buf[k+1], exp_read(ak));
    end
    check("rd_no_strobe", obs_q.size(), 0);
    $display("spi read  addr=%02h len=%0d first=%02h", a, n, rx_buf[1]);
  endtask

  task automatic host_write(input logic [6:0] a, input logic [7:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    if (a != 7'h00) model[a] = d;
    @(negedge clk);
    check("host_rdata_after_write", host_rdata, d);
    $display("host write addr=%02h data=%02h", a, d);
  endtask

  initial begin
    logic [6:0] ra;
    int         rn;

    rst = 1'b1;
    spi.spi_cs_n = 1'b1;
    spi.spi_sclk = 1'b0;
    spi.spi_mosi = 1'b0;
    host_we = 1'b0;
    host_addr = 7'h05;
    host_wdata = 8'h00;
    clear_model();
    repeat (4) @(negedge clk);
    check("rst_miso", spi.spi_miso, 0);
    check("rst_miso_oe", spi.spi_miso_oe, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_host_rdata", host_rdata, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_fe", fe_cnt, 0);

    spi_read(7'h00, 1);

    tx_buf[1] = 8'hA5;
    spi_write(7'h05, 1, -1);
    spi_read(7'h05, 1);
    host_addr = 7'h05;
    repeat (2) @(negedge clk);
    check("host_rd_05", host_rdata, 8'hA5);

    tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    spi_write(7'h7E, 3, -1);
    spi_read(7'h7E, 3);

    fe_cnt = 0;
    obs_q = {};
    tx_buf[0] = 8'h10;
    tx_buf[1] = 8'hFF;
    spi_xfer(13, -1);
    $display("spi partial write addr=10 bits=13 frame_err=%0d", fe_cnt);
    check("frame_err_pulse", fe_cnt, 1);
    check("frame_err_no_strobe", obs_q.size(), 0);
    spi_read(7'h10, 1);
    tx_buf[1] = 8'h5A;
    spi_write(7'h11, 1, -1);
    spi_read(7'h11, 1);
    check("frame_err_once", fe_cnt, 1);

    host_write(7'h21, 8'h3C);
    spi_read(7'h21, 1);

    host_addr  = 7'h20;
    host_wdata = 8'h3C;
    tx_buf[1]  = 8'h99;
    spi_write(7'h20, 1, 15);
    check("collide_strobe_latency", strobe_at_commit, 1);
    check("collide_host_rdata", rdata_after, 8'h99);
    spi_read(7'h20, 1);

    // Reset in the middle of a read of 0x05 with cs_n held low.
    tx_buf[0] = 8'h85;
    tx_buf[1] = 8'h00;
    spi.spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      spi.spi_mosi = tx_buf[i/8][7 - i%8];
      repeat (5) @(negedge clk);
      spi.spi_sclk = 1'b1;
      repeat (5) @(negedge clk);
      spi.spi_sclk = 1'b0;
    end
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_model();
    obs_q = {};
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      spi.spi_mosi = 1'b1;
      repeat (5) @(negedge clk);
      spi.spi_sclk = 1'b1;
      repeat (5) @(negedge clk);
      spi.spi_sclk = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_oe", spi.spi_miso_oe, 0);
      check("midrst_miso", spi.spi_miso, 0);
    end
    check("midrst_no_strobe", obs_q.size(), 0);
    spi.spi_cs_n = 1'b1;
    spi.spi_mosi = 1'b0;
    repeat (10) @(negedge clk);
    $display("reset during read, cs_n held low, then released");
    spi_read(7'h05, 1);
    host_addr = 7'h20;
    repeat (2) @(negedge clk);
    check("midrst_reg20_cleared", host_rdata, 8'h00);

    for (int t = 0; t < 8; t++) begin
      ra = 7'($urandom_range(0, 127));
      rn = $urandom_range(1, 3);
      for (int k = 0; k < rn; k++) tx_buf[k+1] = 8'($urandom);
      spi_write(ra, rn, -1);
      if ($urandom_range(0, 1) == 1)
        host_write(7'($urandom_range(1, 127)), 8'($urandom));
      spi_read(7'($urandom_range(0, 127)), $urandom_range(1, 3));
      spi_read(ra, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
